// File: rtl/clock_switch_pkg.sv
// Shared encodings and helpers for the clock select controller.
package clock_switch_pkg;

    localparam int NUM_REQ = 3;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SWITCH = 2'd1,
        ST_HOLD   = 2'd2
    } state_e;

    localparam logic [1:0] SEL_800M  = 2'b00;
    localparam logic [1:0] SEL_500M  = 2'b01;
    localparam logic [1:0] SEL_1000M = 2'b10;
    localparam logic [1:0] SEL_RSVD  = 2'b11;

    // Reduce 0..5 into a requester index 0..2.
    function automatic logic [1:0] wrap3(input logic [2:0] v);
        return (v >= 3'd3) ? 2'(v - 3'd3) : v[1:0];
    endfunction

    function automatic logic [1:0] oh3_to_idx(input logic [2:0] oh);
        return oh[2] ? 2'd2 : (oh[1] ? 2'd1 : 2'd0);
    endfunction

endpackage

// File: rtl/rr_arb3.sv
// Three-way round-robin pick: first eligible requester at or after rr_ptr.
module rr_arb3
    import clock_switch_pkg::*;
(
    input  logic [2:0] eligible,
    input  logic [1:0] rr_ptr,
    output logic [2:0] winner,
    output logic       valid
);

    logic [1:0] idx;

    always_comb begin
        winner = '0;
        valid  = 1'b0;
        idx    = '0;
        for (int k = 0; k < 3; k++) begin
            idx = wrap3({1'b0, rr_ptr} + 3'(k));
            if (!valid && eligible[idx]) begin
                winner[idx] = 1'b1;
                valid       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/clock_sel_ctrl.sv
// Arbitrated clock-source selector with settle delay before grant.
// Optional forced release of long grants under macro CLK_SEL_TIMEOUT_EN.
module clock_sel_ctrl
    import clock_switch_pkg::*;
#(
    parameter int         SETTLE_CYC = 8,
    parameter int         HOLD_MAX   = 255,
    parameter logic [1:0] RST_SEL    = 2'b00
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req,
    input  logic [2*NUM_REQ-1:0] req_sel,
    output logic [NUM_REQ-1:0]   gnt,
    output logic [1:0]           clk_sel,
    output logic                 busy,
    output logic                 sel_done,
    output logic                 err,
    output logic                 timeout
);

    state_e             state_q, state_d;
    logic [1:0]         owner_q, owner_d;
    logic [1:0]         rr_ptr_q, rr_ptr_d;
    logic [1:0]         clk_sel_q, clk_sel_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [NUM_REQ-1:0] gnt_q, gnt_d;
    logic               busy_q, busy_d;
    logic               sel_done_q, sel_done_d;
    logic               err_q, err_d;

    logic [NUM_REQ-1:0] rsvd, eligible, win_oh;
    logic               win_vld;
    logic [1:0]         win_idx, win_sel;

`ifdef CLK_SEL_TIMEOUT_EN
    logic [NUM_REQ-1:0] mask_q, mask_d;
    logic [7:0]         hold_cnt_q, hold_cnt_d;
    logic               timeout_q, timeout_d;
`endif

    always_comb begin
        rsvd = '0;
        for (int i = 0; i < NUM_REQ; i++)
            rsvd[i] = (req_sel[2*i +: 2] == SEL_RSVD);
    end

`ifdef CLK_SEL_TIMEOUT_EN
    assign eligible = req & ~rsvd & ~mask_q;
`else
    assign eligible = req & ~rsvd;
`endif

    rr_arb3 u_arb (
        .eligible (eligible),
        .rr_ptr   (rr_ptr_q),
        .winner   (win_oh),
        .valid    (win_vld)
    );

    assign win_idx = oh3_to_idx(win_oh);
    assign win_sel = req_sel[{win_idx, 1'b0} +: 2];

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        rr_ptr_d   = rr_ptr_q;
        clk_sel_d  = clk_sel_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        sel_done_d = 1'b0;
        err_d      = |(req & rsvd);
`ifdef CLK_SEL_TIMEOUT_EN
        mask_d     = mask_q & req;
        hold_cnt_d = '0;
        timeout_d  = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (win_vld) begin
                    owner_d = win_idx;
                    if (win_sel != clk_sel_q) begin
                        clk_sel_d = win_sel;
                        cnt_d     = 8'(SETTLE_CYC - 1);
                        state_d   = ST_SWITCH;
                    end else begin
                        gnt_d   = win_oh;
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_SWITCH: begin
                // Settle always runs to completion; a dropped request just skips the grant.
                if (cnt_q == 8'd0) begin
                    sel_done_d = 1'b1;
                    if (req[owner_q]) begin
                        gnt_d   = 3'b001 << owner_q;
                        state_d = ST_HOLD;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_HOLD: begin
                if (!req[owner_q]) begin
                    gnt_d    = '0;
                    rr_ptr_d = wrap3({1'b0, owner_q} + 3'd1);
                    state_d  = ST_IDLE;
                end
`ifdef CLK_SEL_TIMEOUT_EN
                else if (hold_cnt_q == 8'(HOLD_MAX - 1)) begin
                    gnt_d           = '0;
                    timeout_d       = 1'b1;
                    mask_d[owner_q] = 1'b1;
                    rr_ptr_d        = wrap3({1'b0, owner_q} + 3'd1);
                    state_d         = ST_IDLE;
                end else begin
                    hold_cnt_d = hold_cnt_q + 8'd1;
                end
`endif
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            clk_sel_q  <= RST_SEL;
            cnt_q      <= '0;
            gnt_q      <= '0;
            busy_q     <= 1'b0;
            sel_done_q <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            clk_sel_q  <= clk_sel_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            busy_q     <= busy_d;
            sel_done_q <= sel_done_d;
            err_q      <= err_d;
        end
    end

`ifdef CLK_SEL_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            mask_q     <= '0;
            hold_cnt_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            mask_q     <= mask_d;
            hold_cnt_q <= hold_cnt_d;
            timeout_q  <= timeout_d;
        end
    end
    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    assign gnt      = gnt_q;
    assign clk_sel  = clk_sel_q;
    assign busy     = busy_q;
    assign sel_done = sel_done_q;
    assign err      = err_q;

endmodule

// File: tb/tb_clock_sel_ctrl.sv
// Scoreboard bench for clock_sel_ctrl: directed scenarios followed by random traffic.
module tb_clock_sel_ctrl;

    localparam int         SETTLE = 8;
    localparam logic [1:0] RSEL   = 2'b00;
`ifdef CLK_SEL_TIMEOUT_EN
    localparam int HMAX   = 16;
    localparam bit TMO_EN = 1'b1;
`else
    localparam int HMAX   = 255;
    localparam bit TMO_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] req;
    logic [5:0] req_sel;
    logic [2:0] gnt;
    logic [1:0] clk_sel;
    logic       busy, sel_done, err, timeout;

    int checks   = 0;
    int failures = 0;

    clock_sel_ctrl #(.SETTLE_CYC(SETTLE), .HOLD_MAX(HMAX), .RST_SEL(RSEL)) dut (
        .clk(clk), .rst(rst), .req(req), .req_sel(req_sel),
        .gnt(gnt), .clk_sel(clk_sel), .busy(busy),
        .sel_done(sel_done), .err(err), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0] gnt;
        logic [1:0] sel;
        logic       busy;
        logic       done;
        logic       err;
        logic       tmo;
    } exp_t;

    exp_t exp_q[$];

    // Reference model: tracks who owns the clock and at which absolute cycle
    // the settle ends / the grant began, instead of running down counters.
    int         m_phase;   // 0 idle, 1 settling, 2 granted
    int         m_owner, m_ptr;
    longint     m_cyc, m_done_at, m_hold_at;
    logic [1:0] m_sel;
    logic [2:0] m_gnt, m_mask;

    initial begin
        m_cyc = 0; m_phase = 0; m_ptr = 0; m_owner = 0;
        m_sel = RSEL; m_gnt = '0; m_mask = '0;
        m_done_at = 0; m_hold_at = 0;
        forever begin
            exp_t       e;
            logic [2:0] nmask;
            logic [1:0] s;
            int         w;
            bit         found;
            @(posedge clk);
            m_cyc++;
            e = '0;
            if (rst) begin
                m_phase = 0; m_ptr = 0; m_sel = RSEL; m_gnt = '0; m_mask = '0;
            end else begin
                nmask = m_mask & req;
                for (int i = 0; i < 3; i++)
                    if (req[i] && req_sel[2*i +: 2] == 2'b11) e.err = 1'b1;
                case (m_phase)
                    0: begin
                        found = 1'b0; w = 0;
                        for (int k = 0; k < 3; k++) begin
                            int i;
                            i = (m_ptr + k) % 3;
                            if (!found && req[i] && req_sel[2*i +: 2] != 2'b11 && !m_mask[i]) begin
                                found = 1'b1; w = i;
                            end
                        end
                        if (found) begin
                            m_owner = w;
                            s = req_sel[2*w +: 2];
                            if (s != m_sel) begin
                                m_sel = s; m_done_at = m_cyc + SETTLE; m_phase = 1;
                            end else begin
                                m_gnt = 3'(1 << w); m_hold_at = m_cyc; m_phase = 2;
                            end
                        end
                    end
                    1: if (m_cyc == m_done_at) begin
                        e.done = 1'b1;
                        if (req[m_owner]) begin
                            m_gnt = 3'(1 << m_owner); m_hold_at = m_cyc; m_phase = 2;
                        end else m_phase = 0;
                    end
                    default: begin
                        if (!req[m_owner]) begin
                            m_gnt = '0; m_ptr = (m_owner + 1) % 3; m_phase = 0;
                        end else if (TMO_EN && (m_cyc - m_hold_at) == longint'(HMAX)) begin
                            m_gnt = '0; e.tmo = 1'b1; nmask[m_owner] = 1'b1;
                            m_ptr = (m_owner + 1) % 3; m_phase = 0;
                        end
                    end
                endcase
                m_mask = nmask;
            end
            e.gnt  = m_gnt;
            e.sel  = m_sel;
            e.busy = (m_phase != 0);
            exp_q.push_back(e);
        end
    end

    // Monitor: DUT presents registered outputs every cycle; compare on the falling edge.
    initial begin
        forever begin
            exp_t e;
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                checks++;
                if ({gnt, clk_sel, busy, sel_done, err, timeout} !== e) begin
                    failures++;
                    $display("FAIL scoreboard t=%0t got gnt=%b sel=%b busy=%b done=%b err=%b tmo=%b want gnt=%b sel=%b busy=%b done=%b err=%b tmo=%b",
                             $time, gnt, clk_sel, busy, sel_done, err, timeout,
                             e.gnt, e.sel, e.busy, e.done, e.err, e.tmo);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s got=%0h want=%0h t=%0t", name, act, want, $time);
        end
    endtask

    task automatic cyc_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wait_gnt(output logic [2:0] g);
        g = '0;
        for (int i = 0; i < 40 && g == 3'b000; i++) begin
            @(negedge clk);
            g = gnt;
        end
        if (g == 3'b000) begin
            checks++;
            failures++;
            $display("FAIL wait_gnt no grant within 40 cycles t=%0t", $time);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [2:0] g;
        int         ncnt;
        bit         saw_tmo;
        rst = 1'b1; req = '0; req_sel = '0;
        cyc_n(3);
        chk("reset_gnt", 8'(gnt), 8'h0);
        chk("reset_clk_sel", 8'(clk_sel), 8'(RSEL));
        chk("reset_busy", 8'(busy), 8'h0);
        rst = 1'b0;
        cyc_n(1);

        // Source change: select follows at once, grant after the settle time.
        req = 3'b001; req_sel = 6'b00_00_01;
        cyc_n(1);
        chk("switch_clk_sel", 8'(clk_sel), 8'h1);
        chk("switch_busy", 8'(busy), 8'h1);
        cyc_n(SETTLE - 1);
        chk("switch_early_gnt", 8'(gnt), 8'h0);
        cyc_n(1);
        chk("switch_gnt", 8'(gnt), 8'h1);
        chk("switch_sel_done", 8'(sel_done), 8'h1);
        cyc_n(1);
        chk("sel_done_pulse", 8'(sel_done), 8'h0);
        req = '0;
        cyc_n(2);

        // Same source as current: immediate grant, no settle pulse.
        req = 3'b001;
        cyc_n(1);
        chk("same_sel_gnt", 8'(gnt), 8'h1);
        chk("same_sel_no_done", 8'(sel_done), 8'h0);
        req = '0;
        cyc_n(2);

        // Owner 2 releases so the pointer returns to 0.
        req = 3'b100; req_sel = 6'b00_00_00;
        wait_gnt(g);
        chk("prep_gnt", 8'(g), 8'h4);
        req = '0;
        cyc_n(2);

        // All three request; round-robin order from pointer 0.
        req = 3'b111; req_sel = 6'b01_00_10;
        for (int n = 0; n < 3; n++) begin
            wait_gnt(g);
            chk("rr_order", 8'(g), 8'(3'b001 << n));
            cyc_n(5);
            req = req & ~g;
        end
        cyc_n(2);
        req = 3'b111;
        wait_gnt(g);
        chk("rr_wrap_first", 8'(g), 8'h1);
        req = '0;
        cyc_n(2);

        // Reserved source: error flag, never granted.
        req = 3'b010; req_sel = 6'b00_11_00;
        cyc_n(1);
        chk("rsvd_err", 8'(err), 8'h1);
        chk("rsvd_gnt", 8'(gnt), 8'h0);
        chk("rsvd_busy", 8'(busy), 8'h0);
        req = '0;
        cyc_n(1);
        chk("rsvd_err_clear", 8'(err), 8'h0);

        // Reset in the middle of a settle.
        rst = 1'b1; cyc_n(1); rst = 1'b0;
        req = 3'b001; req_sel = 6'b00_00_01;
        cyc_n(3);
        chk("mid_switch_busy", 8'(busy), 8'h1);
        rst = 1'b1;
        cyc_n(1);
        chk("abort_clk_sel", 8'(clk_sel), 8'(RSEL));
        chk("abort_busy", 8'(busy), 8'h0);
        chk("abort_no_done", 8'(sel_done), 8'h0);
        rst = 1'b0; req = '0;
        cyc_n(2);

        if (TMO_EN) begin
            // Held request is forcibly released and stays masked until dropped.
            req = 3'b001; req_sel = 6'b00_00_00;
            ncnt = 0; saw_tmo = 1'b0;
            for (int i = 0; i < 30; i++) begin
                @(negedge clk);
                if (gnt[0]) ncnt++;
                if (timeout) saw_tmo = 1'b1;
            end
            chk("tmo_gnt_len", 8'(ncnt), 8'(HMAX));
            chk("tmo_pulse", 8'(saw_tmo), 8'h1);
            chk("tmo_masked", 8'(gnt), 8'h0);
            req = '0; cyc_n(1);
            req = 3'b001; cyc_n(1);
            chk("tmo_regrant", 8'(gnt), 8'h1);
            req = '0; cyc_n(2);
        end

        // Random traffic against the model.
        for (int c = 0; c < 500; c++) begin
            for (int i = 0; i < 3; i++) begin
                if ($urandom_range(0, 5) == 0) req[i] = ~req[i];
                if ($urandom_range(0, 7) == 0)
                    req_sel[2*i +: 2] = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            end
            rst = ($urandom_range(0, 199) == 0);
            cyc_n(1);
        end
        rst = 1'b0; req = '0;
        cyc_n(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
